// File: rtl/trig_acq_sequencer.sv
// rtl/trig_acq_sequencer.sv - trigger-to-acquisition sequencer (optional WAIT_RD timeout: TRIG_ACQ_TIMEOUT_EN)
module trig_acq_sequencer #(
    parameter int DLY_W       = 8,
    parameter int LEN_W       = 10,
    parameter int OVR_W       = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_out,
    input  logic             trig_strb,
    input  logic [5:0]       pulse_ctr,
    input  logic [DLY_W-1:0] delay,
    input  logic [LEN_W-1:0] win_len,
    input  logic             rd_done,
    output logic             store_en,
    output logic [LEN_W-1:0] wr_addr,
    output logic             frame_valid,
    output logic [5:0]       frame_tag,
    output logic             frame_fb,
    output logic             busy,
    output logic             trig_rdy,
    output logic [OVR_W-1:0] overrun_ctr
`ifdef TRIG_ACQ_TIMEOUT_EN
    ,
    output logic             timeout_flag
`endif
);

    typedef enum logic [1:0] {IDLE, DELAY, ACQ, WAIT_RD} state_t;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wr_addr_q, wr_addr_d;
    logic             store_en_q, store_en_d;
    logic             frame_valid_q, frame_valid_d;
    logic [5:0]       tag_q, tag_d;
    logic             fb_q, fb_d;
    logic             busy_q, busy_d;
    logic             trig_rdy_q, trig_rdy_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             win_go;
    logic [LEN_W-1:0] go_len;
`ifdef TRIG_ACQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d       = state_q;
        dly_cnt_d     = dly_cnt_q;
        len_d         = len_q;
        wr_addr_d     = '0;
        store_en_d    = 1'b0;
        frame_valid_d = 1'b0;
        tag_d         = tag_q;
        fb_d          = fb_q;
        ovr_d         = ovr_q;
        win_go        = 1'b0;
        go_len        = len_q;
`ifdef TRIG_ACQ_TIMEOUT_EN
        to_cnt_d      = '0;
        timeout_d     = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (trig_out) begin
                    len_d = win_len;
                    tag_d = pulse_ctr;
                    fb_d  = trig_strb;
                    if (delay != '0) begin
                        state_d   = DELAY;
                        dly_cnt_d = delay - DLY_W'(1);
                    end else begin
                        win_go = 1'b1;
                        go_len = win_len;
                    end
                end
            end
            DELAY: begin
                if (dly_cnt_q == '0) win_go = 1'b1;
                else dly_cnt_d = dly_cnt_q - DLY_W'(1);
            end
            ACQ: begin
                if (wr_addr_q == len_q - LEN_W'(1)) begin
                    state_d       = WAIT_RD;
                    frame_valid_d = 1'b1;
                end else begin
                    store_en_d = 1'b1;
                    wr_addr_d  = wr_addr_q + LEN_W'(1);
                end
            end
            WAIT_RD: begin
                if (rd_done) begin
                    state_d = IDLE;
`ifdef TRIG_ACQ_TIMEOUT_EN
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // A zero-length window skips ACQ and reports the (empty) frame at once.
        if (win_go) begin
            if (go_len != '0) begin
                state_d    = ACQ;
                store_en_d = 1'b1;
            end else begin
                state_d       = WAIT_RD;
                frame_valid_d = 1'b1;
            end
        end

        if (trig_out && state_q != IDLE && ovr_q != '1) ovr_d = ovr_q + OVR_W'(1);

        busy_d     = (state_d != IDLE);
        trig_rdy_d = (state_q == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            dly_cnt_q     <= '0;
            len_q         <= '0;
            wr_addr_q     <= '0;
            store_en_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            tag_q         <= '0;
            fb_q          <= 1'b0;
            busy_q        <= 1'b0;
            trig_rdy_q    <= 1'b0;
            ovr_q         <= '0;
`ifdef TRIG_ACQ_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            dly_cnt_q     <= dly_cnt_d;
            len_q         <= len_d;
            wr_addr_q     <= wr_addr_d;
            store_en_q    <= store_en_d;
            frame_valid_q <= frame_valid_d;
            tag_q         <= tag_d;
            fb_q          <= fb_d;
            busy_q        <= busy_d;
            trig_rdy_q    <= trig_rdy_d;
            ovr_q         <= ovr_d;
`ifdef TRIG_ACQ_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign store_en    = store_en_q;
    assign wr_addr     = wr_addr_q;
    assign frame_valid = frame_valid_q;
    assign frame_tag   = tag_q;
    assign frame_fb    = fb_q;
    assign busy        = busy_q;
    assign trig_rdy    = trig_rdy_q;
    assign overrun_ctr = ovr_q;
`ifdef TRIG_ACQ_TIMEOUT_EN
    assign timeout_flag = timeout_q;
`endif

endmodule

// File: tb/tb_trig_acq_sequencer.sv
// tb/tb_trig_acq_sequencer.sv - bench for trig_acq_sequencer (define TRIG_ACQ_TIMEOUT_EN for timeout build)
module tb_trig_acq_sequencer;

`ifdef TRIG_ACQ_TIMEOUT_EN
    localparam int TO_CYC = 10;
`else
    localparam int TO_CYC = 65535;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig_out = 1'b0, trig_strb = 1'b0, rd_done = 1'b0;
    logic [5:0] pulse_ctr = '0;
    logic [7:0] delay = '0;
    logic [9:0] win_len = '0;
    logic       store_en, frame_valid, frame_fb, busy, trig_rdy;
    logic [9:0] wr_addr;
    logic [5:0] frame_tag;
    logic [7:0] overrun_ctr;
`ifdef TRIG_ACQ_TIMEOUT_EN
    logic       timeout_flag;
`endif

    trig_acq_sequencer #(.DLY_W(8), .LEN_W(10), .OVR_W(8), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .trig_out(trig_out), .trig_strb(trig_strb),
        .pulse_ctr(pulse_ctr), .delay(delay), .win_len(win_len), .rd_done(rd_done),
        .store_en(store_en), .wr_addr(wr_addr), .frame_valid(frame_valid),
        .frame_tag(frame_tag), .frame_fb(frame_fb), .busy(busy), .trig_rdy(trig_rdy),
        .overrun_ctr(overrun_ctr)
`ifdef TRIG_ACQ_TIMEOUT_EN
        , .timeout_flag(timeout_flag)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    // Reference model: a frame is described by its acceptance cycle and captured timing.
    int   cyc, f_act, f_T, f_D, f_L, f_rd, m_ovr;
    logic [5:0] m_tag;
    logic m_fb, m_rdy_next, m_to;
    logic e_store, e_fv, e_busy, e_rdy, e_fb, e_to;
    int   e_addr, e_ovr;
    logic [5:0] e_tag;

    function automatic bit in_frame(int c);
        return f_act != 0 && c >= f_T + 1 && (f_rd < 0 || c <= f_rd);
    endfunction

    task automatic model_reset();
        cyc = 0; f_act = 0; f_T = 0; f_D = 0; f_L = 0; f_rd = -1; m_ovr = 0;
        m_tag = '0; m_fb = 1'b0; m_to = 1'b0; m_rdy_next = 1'b0;
        e_store = 0; e_fv = 0; e_busy = 0; e_rdy = 0; e_fb = 0; e_to = 0;
        e_addr = 0; e_ovr = 0; e_tag = '0;
    endtask

    task automatic tick();
        bit b;
        int fv;
        b  = in_frame(cyc);
        fv = f_T + 1 + f_D + f_L;
        if (trig_out && b && m_ovr < 255) m_ovr++;
        if (trig_out && !b) begin
            f_act = 1; f_T = cyc; f_D = int'(delay); f_L = int'(win_len); f_rd = -1;
            m_tag = pulse_ctr; m_fb = trig_strb;
        end
        if (rd_done && b && cyc >= fv && f_rd < 0) f_rd = cyc;
`ifdef TRIG_ACQ_TIMEOUT_EN
        if (b && f_rd < 0 && cyc == fv + TO_CYC - 1) begin
            f_rd = cyc; m_to = 1'b1;
        end
`endif
        m_rdy_next = !b;
        @(posedge clk); #1;
        cyc++;
        e_busy  = in_frame(cyc);
        e_store = e_busy && cyc >= f_T + 1 + f_D && cyc <= f_T + f_D + f_L;
        e_addr  = e_store ? cyc - (f_T + 1 + f_D) : 0;
        e_fv    = e_busy && cyc == f_T + 1 + f_D + f_L;
        e_rdy   = m_rdy_next;
        e_tag   = m_tag; e_fb = m_fb; e_ovr = m_ovr; e_to = m_to;
    endtask

    task automatic do_reset();
        trig_out = 0; trig_strb = 0; rd_done = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (store_en !== 1'b0) begin errs++; $display("FAIL reset_store_en got %0b want 0", store_en); end
        checks++; if (wr_addr !== 10'd0) begin errs++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        checks++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL reset_frame_valid got %0b want 0", frame_valid); end
        checks++; if (frame_tag !== 6'd0 || frame_fb !== 1'b0) begin errs++; $display("FAIL reset_tag got %0d/%0b want 0/0", frame_tag, frame_fb); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (trig_rdy !== 1'b0) begin errs++; $display("FAIL reset_trig_rdy_low got %0b want 0", trig_rdy); end
        checks++; if (overrun_ctr !== 8'd0) begin errs++; $display("FAIL reset_overrun got %0d want 0", overrun_ctr); end
        tick();
        checks++; if (trig_rdy !== 1'b1) begin errs++; $display("FAIL reset_trig_rdy_rise got %0b want 1", trig_rdy); end
    endtask

    task automatic test_basic();
        delay = 8'd3; win_len = 10'd4; pulse_ctr = 6'd17; trig_out = 1; trig_strb = 1;
        tick();
        trig_out = 0; trig_strb = 0;
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (store_en !== (k >= 4 && k <= 7)) begin errs++; $display("FAIL basic_store_en T+%0d got %0b", k, store_en); end
            checks++;
            if (wr_addr !== ((k >= 4 && k <= 7) ? 10'(k - 4) : 10'd0)) begin errs++; $display("FAIL basic_wr_addr T+%0d got %0d", k, wr_addr); end
            checks++;
            if (frame_valid !== (k == 8)) begin errs++; $display("FAIL basic_frame_valid T+%0d got %0b", k, frame_valid); end
            if (k == 8) begin
                checks++;
                if (frame_tag !== 6'd17 || frame_fb !== 1'b1) begin errs++; $display("FAIL basic_tag got %0d/%0b want 17/1", frame_tag, frame_fb); end
            end
            if (k >= 11) begin
                checks++;
                if (trig_rdy !== (k == 12)) begin errs++; $display("FAIL basic_trig_rdy T+%0d got %0b", k, trig_rdy); end
            end
            rd_done = (k == 10);
            tick();
            rd_done = 0;
        end
    endtask

    task automatic test_zero_delay();
        delay = 8'd0; win_len = 10'd1; pulse_ctr = 6'd5; trig_out = 1; trig_strb = 0;
        tick();
        trig_out = 0;
        checks++; if (store_en !== 1'b1 || wr_addr !== 10'd0) begin errs++; $display("FAIL zdly_store got %0b/%0d want 1/0", store_en, wr_addr); end
        tick();
        checks++; if (frame_valid !== 1'b1 || store_en !== 1'b0) begin errs++; $display("FAIL zdly_frame_valid got %0b/%0b want 1/0", frame_valid, store_en); end
        checks++; if (frame_fb !== 1'b0 || frame_tag !== 6'd5) begin errs++; $display("FAIL zdly_tag got %0d/%0b want 5/0", frame_tag, frame_fb); end
        rd_done = 1;
        tick();
        rd_done = 0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL zdly_rd_coincident busy got %0b want 0", busy); end
        tick();
    endtask

    task automatic test_zero_len();
        delay = 8'd2; win_len = 10'd0; pulse_ctr = 6'd9; trig_out = 1;
        tick();
        trig_out = 0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (store_en !== 1'b0) begin errs++; $display("FAIL zlen_store_en T+%0d got %0b want 0", k, store_en); end
            checks++;
            if (frame_valid !== (k == 3)) begin errs++; $display("FAIL zlen_frame_valid T+%0d got %0b", k, frame_valid); end
            rd_done = (k == 3);
            tick();
            rd_done = 0;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        delay = 8'd0; win_len = 10'd1; pulse_ctr = 6'd7; trig_out = 1;
        tick();
        trig_out = 0;
        tick();
        rd_done = 1; trig_out = 1; pulse_ctr = 6'd8;
        tick();
        rd_done = 0; pulse_ctr = 6'd9;
        tick();
        trig_out = 0;
        checks++; if (overrun_ctr !== 8'd1) begin errs++; $display("FAIL b2b_overrun got %0d want 1", overrun_ctr); end
        checks++; if (busy !== 1'b1 || store_en !== 1'b1 || frame_tag !== 6'd9) begin errs++; $display("FAIL b2b_accept got busy=%0b store=%0b tag=%0d want 1/1/9", busy, store_en, frame_tag); end
        tick();
        rd_done = 1; tick(); rd_done = 0; tick();
    endtask

    task automatic test_overrun();
        do_reset();
        tick();
        delay = 8'd0; win_len = 10'd20; pulse_ctr = 6'd33; trig_out = 1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            trig_out = (k == 2 || k == 4 || k == 6);
            pulse_ctr = 6'(k);
            tick();
            if (k == 6) begin
                checks++;
                if (overrun_ctr !== 8'd3 || frame_tag !== 6'd33) begin errs++; $display("FAIL ovr_acq got %0d tag %0d want 3 tag 33", overrun_ctr, frame_tag); end
            end
        end
        trig_out = 0;
        checks++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL ovr_frame_valid got %0b want 1", frame_valid); end
        trig_out = 1;
        repeat (300) tick();
        trig_out = 0;
        checks++; if (overrun_ctr !== 8'd255) begin errs++; $display("FAIL ovr_saturate got %0d want 255", overrun_ctr); end
        checks++; if (frame_tag !== 6'd33 || busy !== 1'b1) begin errs++; $display("FAIL ovr_tag got %0d busy %0b want 33 busy 1", frame_tag, busy); end
        rd_done = 1; tick(); rd_done = 0; tick();
    endtask

    task automatic test_reset_mid();
        delay = 8'd1; win_len = 10'd8; trig_out = 1;
        tick();
        trig_out = 0;
        repeat (3) tick();
        checks++; if (store_en !== 1'b1) begin errs++; $display("FAIL rmid_pre got store_en %0b want 1", store_en); end
        rst = 1'b1;
        #1;
        checks++; if (store_en !== 1'b0 || frame_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rmid_async got store=%0b fv=%0b busy=%0b want 0", store_en, frame_valid, busy); end
        checks++; if (overrun_ctr !== 8'd0 || trig_rdy !== 1'b0) begin errs++; $display("FAIL rmid_clear got ovr=%0d rdy=%0b want 0/0", overrun_ctr, trig_rdy); end
        do_reset();
        checks++; if (trig_rdy !== 1'b0) begin errs++; $display("FAIL rmid_rdy_low got %0b want 0", trig_rdy); end
        tick();
        checks++; if (trig_rdy !== 1'b1) begin errs++; $display("FAIL rmid_rdy_rise got %0b want 1", trig_rdy); end
    endtask

`ifdef TRIG_ACQ_TIMEOUT_EN
    task automatic test_timeout();
        delay = 8'd0; win_len = 10'd1; trig_out = 1;
        tick();
        trig_out = 0;
        tick();
        for (int k = 0; k < TO_CYC; k++) begin
            checks++;
            if (busy !== 1'b1 || timeout_flag !== 1'b0) begin errs++; $display("FAIL to_wait W+%0d got busy=%0b flag=%0b want 1/0", k, busy, timeout_flag); end
            tick();
        end
        checks++; if (busy !== 1'b0 || timeout_flag !== 1'b1) begin errs++; $display("FAIL to_fire got busy=%0b flag=%0b want 0/1", busy, timeout_flag); end
        repeat (3) tick();
        checks++; if (timeout_flag !== 1'b1) begin errs++; $display("FAIL to_sticky got %0b want 1", timeout_flag); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 4000 && errs < 60; n++) begin
            checks++; if (store_en !== e_store) begin errs++; $display("FAIL rnd_store_en cyc %0d got %0b want %0b", cyc, store_en, e_store); end
            checks++; if (wr_addr !== 10'(e_addr)) begin errs++; $display("FAIL rnd_wr_addr cyc %0d got %0d want %0d", cyc, wr_addr, e_addr); end
            checks++; if (frame_valid !== e_fv) begin errs++; $display("FAIL rnd_frame_valid cyc %0d got %0b want %0b", cyc, frame_valid, e_fv); end
            checks++; if (busy !== e_busy) begin errs++; $display("FAIL rnd_busy cyc %0d got %0b want %0b", cyc, busy, e_busy); end
            checks++; if (trig_rdy !== e_rdy) begin errs++; $display("FAIL rnd_trig_rdy cyc %0d got %0b want %0b", cyc, trig_rdy, e_rdy); end
            checks++; if (frame_tag !== e_tag || frame_fb !== e_fb) begin errs++; $display("FAIL rnd_tag cyc %0d got %0d/%0b want %0d/%0b", cyc, frame_tag, frame_fb, e_tag, e_fb); end
            checks++; if (overrun_ctr !== 8'(e_ovr)) begin errs++; $display("FAIL rnd_overrun cyc %0d got %0d want %0d", cyc, overrun_ctr, e_ovr); end
`ifdef TRIG_ACQ_TIMEOUT_EN
            checks++; if (timeout_flag !== e_to) begin errs++; $display("FAIL rnd_timeout cyc %0d got %0b want %0b", cyc, timeout_flag, e_to); end
`endif
            trig_out  = ($urandom_range(0, 7) == 0);
            trig_strb = trig_out & 1'($urandom_range(0, 1));
            pulse_ctr = 6'($urandom_range(0, 63));
            rd_done   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) delay = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) win_len = 10'($urandom_range(0, 9));
            tick();
        end
        trig_out = 0; trig_strb = 0; rd_done = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_zero_delay();
        test_zero_len();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
`ifdef TRIG_ACQ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
